booth_mac_accumulator: RTL and testbench
========================================

# booth_mac_accumulator

Downstream consumer of the 8x8 signed Booth multiplier. It accepts a stream of signed 16-bit products over a valid/ready handshake and sums a programmed number of them into a saturating signed accumulator. It then presents the dot-product result over a second valid/ready handshake. It turns the multiplier's per-pair products into a frame-level MAC result for the datapath.

## Interface

Parameters:
- PROD_W, 16: product width; matches the multiplier's Product output.
- ACC_W, 20: accumulator/result width, signed; must be >= PROD_W.
- LEN_W, 8: width of frame length; a frame holds 0..2^LEN_W-1 products.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a frame; sampled only in IDLE.
- frame_len  input  LEN_W  number of products in the frame; latched on accepted start.
- product  input  PROD_W  signed product from the multiplier.
- prod_valid  input  1  product is valid.
- prod_ready  output  1  block accepts product this cycle.
- result  output  ACC_W  signed accumulated sum; stable while res_valid=1.
- overflow  output  1  sticky per frame: saturation occurred; valid with res_valid.
- res_valid  output  1  result available.
- res_ready  input  1  downstream takes result.
- busy  output  1  high in ACCUM and DONE.

## Operation

- States: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready=0, res_valid=0.
  - start=1 with frame_len!=0: latch len, clear acc and count, clear overflow, go to ACCUM.
  - start=1 with frame_len=0: clear acc and overflow, go directly to DONE (result=0).
- ACCUM:
  - prod_ready=1.
  - Each cycle with prod_valid&prod_ready: acc <= sat(acc + sign_extend(product)), count <= count+1.
  - When the accepted product is number len (count==len-1 at acceptance), go to DONE.
  - prod_valid low: hold state; no change.
- DONE:
  - res_valid=1, prod_ready=0; result=acc, overflow as accumulated.
  - Outputs must not change until res_ready=1; on res_valid&res_ready go to IDLE.
- start is ignored outside IDLE, including the handoff cycle DONE->IDLE.
- Saturation: the add is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to that value (524287 at default).
  - Below -2^(ACC_W-1): clamp to that value (-524288 at default).
  - Either clamp sets overflow=1.
  - Later products keep accumulating from the clamped value; overflow stays set.
- Counter is LEN_W bits; it never wraps because the exit occurs at len.

## Timing

- Reset values (async, immediate on rst rising; held while rst=1):
  - state=IDLE.
  - acc=0, result=0, count=0, overflow=0.
  - prod_ready=0, res_valid=0, busy=0.
- Reset mid-frame discards all partial state; the first cycle after rst deassert is IDLE.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- start accepted at edge N: prod_ready=1 and busy=1 from cycle N+1.
- Last product accepted at edge M: res_valid=1 with final result from cycle M+1. Accumulate-to-result latency is 1 cycle.
- Zero-length frame: res_valid=1 in the cycle after start.
- Throughput: one product per cycle in ACCUM. Back-to-back frames cost 2 idle cycles (DONE->IDLE, then IDLE->ACCUM).
- A product accepted on the same edge as the transition to DONE is the last one. No product is accepted in DONE or IDLE.

## Test plan

- Reset: assert rst asynchronously mid-ACCUM after 3 products -> all outputs 0 immediately, state IDLE. After release, a new frame with len=1 and product=5 -> result=5.
- Basic dot product: len=4, products 100, -200, 16384, -16256 streamed back-to-back -> res_valid on the cycle after the 4th accept, result=28, overflow=0.
- Backpressure and gaps:
  - len=3, products 7, 7, 7 with prod_valid low for 2 cycles between each -> result=21.
  - Hold res_ready=0 for 5 cycles -> result and res_valid stable; start pulses during DONE are ignored.
- Positive saturation: len=33, all products 16384 -> result=524287, overflow=1.
- Negative saturation with recovery:
  - len=34: 33 x (-16384), then +16384 -> clamps at -524288, final result=-507904, overflow=1.
  - Next frame: len=1, product=1 -> overflow=0, result=1.
- Zero-length frame: start with frame_len=0 -> prod_ready never asserts, res_valid the next cycle with result=0, overflow=0.

Source files
------------

// File: rtl/booth_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_mac_accumulator
// Purpose  : Sums a programmed number of signed products into a saturating
//            accumulator and hands the dot-product result downstream.
// Revision : 1.0
// ============================================================================
module booth_mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [PROD_W-1:0] product,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W:0]     sum_w;
  logic               sum_ovf_w;
  logic [ACC_W-1:0]   clamp_w;

  // One guard bit lets the sign disagreement expose overflow in either direction.
  assign sum_w     = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W-PROD_W+1){product[PROD_W-1]}}, product};
  assign sum_ovf_w = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign clamp_w   = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          len_d   = frame_len;
          state_d = (frame_len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_d   = sum_ovf_w ? clamp_w : sum_w[ACC_W-1:0];
          ovf_d   = ovf_q | sum_ovf_w;
          count_d = count_q + C_ONE;
          if (count_q == len_q - C_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode from state only, so no input reaches an output.
  assign prod_ready = (state_q == S_ACCUM);
  assign res_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign result     = acc_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mac_accumulator
// Purpose  : Directed scoreboard bench for booth_mac_accumulator.
// Revision : 1.0
// ============================================================================
module tb_booth_mac_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;
  localparam int MAXV   = (1 << (ACC_W-1)) - 1;
  localparam int MINV   = -(1 << (ACC_W-1));

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic [PROD_W-1:0] product;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  booth_mac_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .product   (product),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .result    (result),
    .overflow  (overflow),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  typedef struct {
    int res;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   stim[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent saturating reference built from plain integer arithmetic.
  task automatic push_expected(input int len);
    int a;
    int o;
    a = 0;
    o = 0;
    for (int i = 0; i < len; i++) begin
      a = a + stim[i];
      if (a > MAXV) begin a = MAXV; o = 1; end
      if (a < MINV) begin a = MINV; o = 1; end
    end
    sb.push_back('{a, o});
  endtask

  task automatic send_frame(input int len, input int gap);
    int p;
    push_expected(len);
    start     = 1'b1;
    frame_len = len[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("prod_ready_after_start", prod_ready, (len != 0) ? 1 : 0);
    for (int i = 0; i < len; i++) begin
      p          = stim[i];
      prod_valid = 1'b1;
      product    = p[PROD_W-1:0];
      @(posedge clk); #1;
      prod_valid = 1'b0;
      if (i != len - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk("ready_held_in_gap", prod_ready, 1);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic take_result(input int hold);
    exp_t e;
    chk("res_valid_latency", res_valid, 1);
    chk("prod_ready_low_done", prod_ready, 0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb[0];
      for (int h = 0; h < hold; h++) begin
        start     = h[0];
        frame_len = 8'd3;
        @(posedge clk); #1;
        chk("hold_res_valid", res_valid, 1);
        chk("hold_result", $signed(result), e.res);
        chk("hold_overflow", overflow, e.ovf);
      end
      e = sb.pop_front();
      chk("result", $signed(result), e.res);
      chk("overflow", overflow, e.ovf);
    end
    // start held through the handoff edge must not launch a frame.
    res_ready = 1'b1;
    start     = 1'b1;
    frame_len = 8'd2;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    chk("idle_res_valid", res_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    start      = 1'b0;
    frame_len  = '0;
    product    = '0;
    prod_valid = 1'b0;
    res_ready  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", $signed(result), 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-frame after 3 products, then a fresh single-product frame.
    stim = '{11, 22, 33};
    start     = 1'b1;
    frame_len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      product    = 16'(stim[i]);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_prod_ready", prod_ready, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_result", $signed(result), 0);
    chk("async_rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stim = '{5};
    send_frame(1, 0);
    take_result(0);

    stim = '{100, -200, 16384, -16256};
    send_frame(4, 0);
    take_result(0);

    stim = '{7, 7, 7};
    send_frame(3, 2);
    take_result(5);

    stim.delete();
    for (int i = 0; i < 33; i++) stim.push_back(16384);
    send_frame(33, 0);
    take_result(0);

    stim.delete();
    for (int i = 0; i < 33; i++) stim.push_back(-16384);
    stim.push_back(16384);
    send_frame(34, 0);
    take_result(2);

    stim = '{1};
    send_frame(1, 0);
    take_result(0);

    stim.delete();
    send_frame(0, 0);
    take_result(1);

    stim = '{-3, 32767, -32768, 12};
    send_frame(4, 1);
    take_result(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
